// File: rtl/keypad_input_ctrl.sv
// keypad_input_ctrl
// Scans a 4x4 active-low matrix keypad, synchronises and debounces the columns,
// and turns one stable keypress into a single held command for gencon.
// A command is held until key_read. The next key is accepted only after the
// keypad has been seen fully released.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_IDLE      | waiting for exactly one debounced key (D ignored)
// ST_PRESENT   | command outputs held until gencon pulses key_read
// ST_RELEASE   | outputs cleared, waiting for a debounced all-released keypad
module keypad_input_ctrl #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] kp_col_n,
    output logic [3:0] kp_row_n,
    input  logic       key_read,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_SCANS);

    // key D sits at row3/col3 and never produces a command
    localparam logic [15:0] KEY_MASK = 16'h7FFF;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [3:0]        col_meta;
    logic [3:0]        col_sync;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        row_idx;
    logic [11:0]       raw_acc;
    logic              sample_now;
    logic              scan_done;
    logic [15:0]       raw_vec;
    logic [15:0]       prev_vec;
    logic [15:0]       stable_vec;
    logic [DB_W-1:0]   stable_cnt;
    logic [DB_W-1:0]   cnt_next;
    logic              stable_upd;
    logic [15:0]       key_vec;
    logic [4:0]        key_cnt;
    logic [3:0]        key_idx;
    logic              single_key;
    logic [1:0]        state;
    logic [3:0]        dec_digit;
    logic              dec_read;
    logic [2:0]        dec_op;
    logic              dec_eq;

    // Two-flop synchroniser on the asynchronous column inputs
    always_ff @(posedge clk) begin
        if (RST) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= kp_col_n;
            col_sync <= col_meta;
        end
    end

    assign sample_now = (scan_cnt == SCAN_LAST);
    assign scan_done  = sample_now && (row_idx == 2'd3);
    assign raw_vec    = {~col_sync, raw_acc};

    // Row dwell timer and row rotation; each row is sampled on its last dwell cycle
    always_ff @(posedge clk) begin
        if (RST) begin
            scan_cnt <= '0;
            row_idx  <= 2'd0;
            kp_row_n <= 4'b1110;
            raw_acc  <= '0;
        end else if (sample_now) begin
            scan_cnt <= '0;
            row_idx  <= row_idx + 2'd1;
            kp_row_n <= {kp_row_n[2:0], kp_row_n[3]};
            case (row_idx)
                2'd0:    raw_acc[3:0]  <= ~col_sync;
                2'd1:    raw_acc[7:4]  <= ~col_sync;
                2'd2:    raw_acc[11:8] <= ~col_sync;
                default: raw_acc       <= raw_acc;
            endcase
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Next stable-scan count: saturating run length of identical full scans
    always_comb begin
        cnt_next = DB_W'(1);
        if (raw_vec == prev_vec) begin
            cnt_next = (stable_cnt == DB_MAX) ? stable_cnt : stable_cnt + DB_W'(1);
        end
    end

    // Debounce on full-scan boundaries; stable_upd marks a fresh stable vector
    always_ff @(posedge clk) begin
        if (RST) begin
            prev_vec   <= '0;
            stable_vec <= '0;
            stable_cnt <= '0;
            stable_upd <= 1'b0;
        end else begin
            stable_upd <= 1'b0;
            if (scan_done) begin
                prev_vec   <= raw_vec;
                stable_cnt <= cnt_next;
                if (cnt_next == DB_MAX) begin
                    stable_vec <= raw_vec;
                    stable_upd <= 1'b1;
                end
            end
        end
    end

    assign key_vec    = stable_vec & KEY_MASK;
    assign single_key = (key_cnt == 5'd1);

    // Population count and position of the pressed key (meaningful when single)
    always_comb begin
        key_cnt = '0;
        key_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (key_vec[i]) begin
                key_cnt = key_cnt + 5'd1;
                key_idx = 4'(i);
            end
        end
    end

    // Map key position to a gencon command
    always_comb begin
        dec_digit = 4'd0;
        dec_read  = 1'b0;
        dec_op    = 3'd0;
        dec_eq    = 1'b0;
        case (key_idx)
            4'd0:  begin dec_read = 1'b1; dec_digit = 4'd1; end
            4'd1:  begin dec_read = 1'b1; dec_digit = 4'd2; end
            4'd2:  begin dec_read = 1'b1; dec_digit = 4'd3; end
            4'd3:  dec_op = 3'd2;
            4'd4:  begin dec_read = 1'b1; dec_digit = 4'd4; end
            4'd5:  begin dec_read = 1'b1; dec_digit = 4'd5; end
            4'd6:  begin dec_read = 1'b1; dec_digit = 4'd6; end
            4'd7:  dec_op = 3'd3;
            4'd8:  begin dec_read = 1'b1; dec_digit = 4'd7; end
            4'd9:  begin dec_read = 1'b1; dec_digit = 4'd8; end
            4'd10: begin dec_read = 1'b1; dec_digit = 4'd9; end
            4'd11: dec_op = 3'd4;
            4'd12: dec_op = 3'd1;
            4'd13: begin dec_read = 1'b1; dec_digit = 4'd0; end
            4'd14: dec_eq = 1'b1;
            default: ;
        endcase
    end

    // Command FSM with registered outputs
    always_ff @(posedge clk) begin
        if (RST) begin
            state          <= ST_IDLE;
            keypad_input   <= 4'd0;
            read_input     <= 1'b0;
            operator_input <= 3'd0;
            equal_input    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (single_key) begin
                        keypad_input   <= dec_digit;
                        read_input     <= dec_read;
                        operator_input <= dec_op;
                        equal_input    <= dec_eq;
                        state          <= ST_PRESENT;
                    end else begin
                        keypad_input   <= 4'd0;
                        read_input     <= 1'b0;
                        operator_input <= 3'd0;
                        equal_input    <= 1'b0;
                    end
                end
                ST_PRESENT: begin
                    if (key_read) begin
                        keypad_input   <= 4'd0;
                        read_input     <= 1'b0;
                        operator_input <= 3'd0;
                        equal_input    <= 1'b0;
                        state          <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (stable_upd && (key_vec == 16'd0)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    keypad_input   <= 4'd0;
                    read_input     <= 1'b0;
                    operator_input <= 3'd0;
                    equal_input    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_input_ctrl.sv
// Directed bench for keypad_input_ctrl with a behavioural 4x4 key matrix.
module tb_keypad_input_ctrl;

    logic       clk;
    logic       RST;
    logic [3:0] kp_col_n;
    logic [3:0] kp_row_n;
    logic       key_read;
    logic [3:0] keypad_input;
    logic       read_input;
    logic [2:0] operator_input;
    logic       equal_input;

    logic [15:0] pressed;
    logic [8:0]  obs;
    int tests_run;
    int tests_failed;
    int cmd_count;
    int onehot_viol;
    logic prev_active;

    keypad_input_ctrl #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk            (clk),
        .RST            (RST),
        .kp_col_n       (kp_col_n),
        .kp_row_n       (kp_row_n),
        .key_read       (key_read),
        .keypad_input   (keypad_input),
        .read_input     (read_input),
        .operator_input (operator_input),
        .equal_input    (equal_input)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a pressed key shorts its column to a row driven low
    always_comb begin
        kp_col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!kp_row_n[r])
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c]) kp_col_n[c] = 1'b0;
    end

    assign obs = {read_input, keypad_input, operator_input, equal_input};

    // Counts new commands and violations of output exclusivity
    initial begin
        cmd_count   = 0;
        onehot_viol = 0;
        prev_active = 1'b0;
    end
    always @(negedge clk) begin
        if (!RST) begin
            if ((int'(read_input) + int'(operator_input != 3'd0) + int'(equal_input)) > 1)
                onehot_viol++;
            if ((obs != 9'd0) && !prev_active) cmd_count++;
        end
        prev_active = (obs != 9'd0);
    end

    task automatic wait_cmd(input int max_cyc, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < max_cyc && !ok) begin
            @(negedge clk);
            cyc++;
            if (obs != 9'd0) ok = 1'b1;
        end
    endtask

    task automatic watch_quiet(input int n, output int hits);
        hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (obs != 9'd0) hits++;
        end
    endtask

    task automatic ack;
        key_read = 1'b1;
        @(negedge clk);
        key_read = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1; key_read = 1'b0; pressed = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (obs !== 9'd0) begin tests_failed++; $display("FAIL reset_outputs: got %h expected %h", obs, 9'd0); end
        tests_run++;
        if (kp_row_n !== 4'b1110) begin tests_failed++; $display("FAIL reset_row: got %b expected %b", kp_row_n, 4'b1110); end
        RST = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (kp_row_n !== 4'b1110) begin tests_failed++; $display("FAIL dwell_row0: got %b expected %b", kp_row_n, 4'b1110); end
        @(negedge clk);
        tests_run++;
        if (kp_row_n !== 4'b1101) begin tests_failed++; $display("FAIL row_advance: got %b expected %b", kp_row_n, 4'b1101); end
        repeat (12) @(negedge clk);
        tests_run++;
        if (kp_row_n !== 4'b1110) begin tests_failed++; $display("FAIL row_wrap: got %b expected %b", kp_row_n, 4'b1110); end
    endtask

    task automatic test_digit;
        int cyc, hits, held_err; bit ok;
        pressed[8] = 1'b1;
        wait_cmd(80, cyc, ok);
        tests_run++;
        if (cyc > 51) begin tests_failed++; $display("FAIL t1_latency: got %0d expected <= 51", cyc); end
        tests_run++;
        if (obs !== {1'b1, 4'd7, 3'd0, 1'b0}) begin tests_failed++; $display("FAIL t1_value: got %h expected %h", obs, {1'b1, 4'd7, 3'd0, 1'b0}); end
        held_err = 0;
        repeat (5) begin
            @(negedge clk);
            if (obs !== {1'b1, 4'd7, 3'd0, 1'b0}) held_err++;
        end
        tests_run++;
        if (held_err != 0) begin tests_failed++; $display("FAIL t1_hold: got %0d bad cycles expected 0", held_err); end
        ack();
        tests_run++;
        if (obs !== 9'd0) begin tests_failed++; $display("FAIL t1_ack_clear: got %h expected %h", obs, 9'd0); end
        pressed = '0;
        watch_quiet(100, hits);
        tests_run++;
        if (hits != 0) begin tests_failed++; $display("FAIL t1_quiet: got %0d active cycles expected 0", hits); end
    endtask

    task automatic test_operator_hold;
        int cyc, hits, held_err; bit ok;
        pressed[3] = 1'b1;
        wait_cmd(80, cyc, ok);
        tests_run++;
        if (obs !== {1'b0, 4'd0, 3'd2, 1'b0}) begin tests_failed++; $display("FAIL t2_value: got %h expected %h", obs, {1'b0, 4'd0, 3'd2, 1'b0}); end
        held_err = 0;
        repeat (200) begin
            @(negedge clk);
            if (obs !== {1'b0, 4'd0, 3'd2, 1'b0}) held_err++;
        end
        pressed = '0;
        repeat (50) begin
            @(negedge clk);
            if (obs !== {1'b0, 4'd0, 3'd2, 1'b0}) held_err++;
        end
        tests_run++;
        if (held_err != 0) begin tests_failed++; $display("FAIL t2_hold: got %0d bad cycles expected 0", held_err); end
        ack();
        tests_run++;
        if (obs !== 9'd0) begin tests_failed++; $display("FAIL t2_ack_clear: got %h expected %h", obs, 9'd0); end
        watch_quiet(100, hits);
        tests_run++;
        if (hits != 0) begin tests_failed++; $display("FAIL t2_single_cmd: got %0d active cycles expected 0", hits); end
    endtask

    task automatic test_equal_hold;
        int cyc, hits; bit ok;
        pressed[14] = 1'b1;
        wait_cmd(80, cyc, ok);
        tests_run++;
        if (obs !== {1'b0, 4'd0, 3'd0, 1'b1}) begin tests_failed++; $display("FAIL t3_value: got %h expected %h", obs, {1'b0, 4'd0, 3'd0, 1'b1}); end
        key_read = 1'b1;
        @(negedge clk);
        tests_run++;
        if (obs !== 9'd0) begin tests_failed++; $display("FAIL t3_ack_clear: got %h expected %h", obs, 9'd0); end
        watch_quiet(500, hits);
        tests_run++;
        if (hits != 0) begin tests_failed++; $display("FAIL t3_no_refire: got %0d active cycles expected 0", hits); end
        pressed = '0;
        watch_quiet(100, hits);
        tests_run++;
        if (hits != 0) begin tests_failed++; $display("FAIL t3_release_quiet: got %0d active cycles expected 0", hits); end
        key_read = 1'b0;
        pressed[14] = 1'b1;
        wait_cmd(80, cyc, ok);
        tests_run++;
        if (obs !== {1'b0, 4'd0, 3'd0, 1'b1}) begin tests_failed++; $display("FAIL t3_refire_after_release: got %h expected %h", obs, {1'b0, 4'd0, 3'd0, 1'b1}); end
        ack();
        pressed = '0;
        watch_quiet(100, hits);
    endtask

    task automatic test_bounce;
        int c0, hits;
        c0 = cmd_count;
        for (int i = 0; i < 20; i++) begin
            pressed[4] = ~pressed[4];
            repeat (3) @(negedge clk);
        end
        pressed[4] = 1'b1;
        repeat (100) @(negedge clk);
        tests_run++;
        if (cmd_count - c0 != 1) begin tests_failed++; $display("FAIL t4_one_cmd: got %0d commands expected 1", cmd_count - c0); end
        tests_run++;
        if (obs !== {1'b1, 4'd4, 3'd0, 1'b0}) begin tests_failed++; $display("FAIL t4_value: got %h expected %h", obs, {1'b1, 4'd4, 3'd0, 1'b0}); end
        ack();
        pressed = '0;
        watch_quiet(100, hits);
        tests_run++;
        if (hits != 0) begin tests_failed++; $display("FAIL t4_quiet: got %0d active cycles expected 0", hits); end
    endtask

    task automatic test_two_keys;
        int cyc, hits; bit ok;
        pressed[5] = 1'b1;
        pressed[7] = 1'b1;
        watch_quiet(120, hits);
        tests_run++;
        if (hits != 0) begin tests_failed++; $display("FAIL t5_multi_blocked: got %0d active cycles expected 0", hits); end
        pressed[7] = 1'b0;
        wait_cmd(80, cyc, ok);
        tests_run++;
        if (obs !== {1'b1, 4'd5, 3'd0, 1'b0}) begin tests_failed++; $display("FAIL t5_value: got %h expected %h", obs, {1'b1, 4'd5, 3'd0, 1'b0}); end
        ack();
        pressed = '0;
        watch_quiet(100, hits);
    endtask

    task automatic test_reset_mid;
        int cyc, hits, c0; bit ok;
        pressed[12] = 1'b1;
        wait_cmd(80, cyc, ok);
        tests_run++;
        if (obs !== {1'b0, 4'd0, 3'd1, 1'b0}) begin tests_failed++; $display("FAIL t6_value: got %h expected %h", obs, {1'b0, 4'd0, 3'd1, 1'b0}); end
        RST = 1'b1;
        @(negedge clk);
        tests_run++;
        if (obs !== 9'd0) begin tests_failed++; $display("FAIL t6_rst_outputs: got %h expected %h", obs, 9'd0); end
        tests_run++;
        if (kp_row_n !== 4'b1110) begin tests_failed++; $display("FAIL t6_rst_row: got %b expected %b", kp_row_n, 4'b1110); end
        RST = 1'b0;
        c0 = cmd_count;
        wait_cmd(80, cyc, ok);
        tests_run++;
        if (obs !== {1'b0, 4'd0, 3'd1, 1'b0}) begin tests_failed++; $display("FAIL t6_after_reset: got %h expected %h", obs, {1'b0, 4'd0, 3'd1, 1'b0}); end
        ack();
        watch_quiet(100, hits);
        tests_run++;
        if (cmd_count - c0 != 1) begin tests_failed++; $display("FAIL t6_once: got %0d commands expected 1", cmd_count - c0); end
        pressed = '0;
        watch_quiet(100, hits);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RST          = 1'b1;
        key_read     = 1'b0;
        pressed      = '0;
        test_reset();
        test_digit();
        test_operator_hold();
        test_equal_hold();
        test_bounce();
        test_two_keys();
        test_reset_mid();
        tests_run++;
        if (onehot_viol != 0) begin tests_failed++; $display("FAIL exclusive_outputs: got %0d bad cycles expected 0", onehot_viol); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
